// File: rtl/message_pkg.sv
// -----------------------------------------------------------------------------
// message_pkg
// Shared definitions for the message stream combiner/splitter pair and their
// benches: header flag position, length/destination field placement, and the
// splitter FSM state encoding.
//
// Header word layout (MSB first):
//   [WIDTH-1]                                  header flag (1 = header)
//   [WIDTH-2 -: LOG_MAX_PACKET_LENGTH]         payload length in words
//   [WIDTH-2-LOG_MAX_PACKET_LENGTH -: LOG_N]   destination stream
//   remaining low bits                         unused by the splitter
// -----------------------------------------------------------------------------
package message_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FORWARD = 2'd1,
      ST_DISCARD = 2'd2
   } state_e;

   function automatic int hdr_flag_pos(input int width);
      return width - 1;
   endfunction

   function automatic int len_msb(input int width);
      return width - 2;
   endfunction

   function automatic int dest_msb(input int width, input int log_len);
      return width - 2 - log_len;
   endfunction

   // Lowest bit position of the destination field; bits below it are spare.
   function automatic int dest_lsb(input int width, input int log_len, input int log_n);
      return width - 1 - log_len - log_n;
   endfunction

endpackage

// File: rtl/message_header_decoder.sv
// -----------------------------------------------------------------------------
// message_header_decoder
// Purely combinational split of a stream word into its header fields.
//
// Ports:
//   word_i        stream word under inspection
//   is_header_o   header flag bit of the word
//   length_o      payload length field
//   dest_o        destination stream field
//   dest_valid_o  destination addresses an existing stream (< N_STREAMS)
// -----------------------------------------------------------------------------
module message_header_decoder
   import message_pkg::*;
#(
   parameter int N_STREAMS             = 4,
   parameter int LOG_N_STREAMS         = 2,
   parameter int WIDTH                 = 32,
   parameter int LOG_MAX_PACKET_LENGTH = 10
) (
   input  logic [WIDTH-1:0]                 word_i,
   output logic                             is_header_o,
   output logic [LOG_MAX_PACKET_LENGTH-1:0] length_o,
   output logic [LOG_N_STREAMS-1:0]         dest_o,
   output logic                             dest_valid_o
);

   localparam int FLAG_POS = hdr_flag_pos(WIDTH);
   localparam int LEN_MSB  = len_msb(WIDTH);
   localparam int DEST_MSB = dest_msb(WIDTH, LOG_MAX_PACKET_LENGTH);
   localparam int DEST_LSB = dest_lsb(WIDTH, LOG_MAX_PACKET_LENGTH, LOG_N_STREAMS);

   assign is_header_o  = word_i[FLAG_POS];
   assign length_o     = word_i[LEN_MSB -: LOG_MAX_PACKET_LENGTH];
   assign dest_o       = word_i[DEST_MSB -: LOG_N_STREAMS];
   // Compared at 32 bits so a non-power-of-two stream count is handled.
   assign dest_valid_o = (32'(dest_o) < 32'(N_STREAMS));

   // Spare low bits of the header carry no meaning for routing.
   if (DEST_LSB > 0) begin : g_spare
      logic unused_spare_bits;
      assign unused_spare_bits = ^word_i[DEST_LSB-1:0];
   end

endmodule

// File: rtl/message_stream_splitter.sv
// -----------------------------------------------------------------------------
// message_stream_splitter
// Routes header-framed packets from one combined stream to one of N_STREAMS
// output streams selected by the header's destination field. One registered
// output word per accepted input word, one cycle of latency, no backpressure.
// Orphan words (non-header while idle) and headers with an out-of-range
// destination are dropped and raise the sticky error flag; the payload of a
// rejected packet is swallowed.
//
// Build option:
//   MESSAGE_SPLITTER_STRIP_HEADER_EN  when defined, header words are consumed
//                                     and only payload words are emitted
//                                     (a length-0 packet emits nothing).
//
// Ports:
//   clk       clock
//   rst_n     synchronous active-low reset
//   in_data   combined stream word
//   in_nd     in_data valid this cycle
//   out_data  stream k at bits [WIDTH*(k+1)-1 -: WIDTH], holds when idle
//   out_nd    per-stream valid pulse (one-hot or zero)
//   out_last  per-stream last-word-of-packet pulse
//   error     sticky flag, cleared only by reset
// -----------------------------------------------------------------------------
module message_stream_splitter
   import message_pkg::*;
#(
   parameter int N_STREAMS             = 4,
   parameter int LOG_N_STREAMS         = 2,
   parameter int WIDTH                 = 32,
   parameter int MAX_PACKET_LENGTH     = 1024,
   parameter int LOG_MAX_PACKET_LENGTH = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_nd,
   output logic [WIDTH*N_STREAMS-1:0]   out_data,
   output logic [N_STREAMS-1:0]         out_nd,
   output logic [N_STREAMS-1:0]         out_last,
   output logic                         error
);

   localparam int LEN_W = LOG_MAX_PACKET_LENGTH;
   // The length field width alone bounds packet size; the nominal maximum is
   // carried for parameter compatibility with the combiner.
   localparam int max_len_unused = MAX_PACKET_LENGTH;

   state_e                         state_q, state_d;
   logic [LOG_N_STREAMS-1:0]       dest_q, dest_d;
   logic [LEN_W-1:0]               remaining_q, remaining_d;
   logic                           error_q, error_d;
   logic [WIDTH*N_STREAMS-1:0]     out_data_q, out_data_d;
   logic [N_STREAMS-1:0]           out_nd_q, out_nd_d;
   logic [N_STREAMS-1:0]           out_last_q, out_last_d;

   logic                           hdr_is_header;
   logic [LEN_W-1:0]               hdr_length;
   logic [LOG_N_STREAMS-1:0]       hdr_dest;
   logic                           hdr_dest_valid;

   logic                           fwd_en;
   logic [LOG_N_STREAMS-1:0]       fwd_dest;
   logic                           fwd_last;

   message_header_decoder #(
      .N_STREAMS             (N_STREAMS),
      .LOG_N_STREAMS         (LOG_N_STREAMS),
      .WIDTH                 (WIDTH),
      .LOG_MAX_PACKET_LENGTH (LOG_MAX_PACKET_LENGTH)
   ) u_hdr_dec (
      .word_i       (in_data),
      .is_header_o  (hdr_is_header),
      .length_o     (hdr_length),
      .dest_o       (hdr_dest),
      .dest_valid_o (hdr_dest_valid)
   );

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         dest_q      <= '0;
         remaining_q <= '0;
         error_q     <= 1'b0;
         out_data_q  <= '0;
         out_nd_q    <= '0;
         out_last_q  <= '0;
      end else begin
         state_q     <= state_d;
         dest_q      <= dest_d;
         remaining_q <= remaining_d;
         error_q     <= error_d;
         out_data_q  <= out_data_d;
         out_nd_q    <= out_nd_d;
         out_last_q  <= out_last_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      dest_d      = dest_q;
      remaining_d = remaining_q;
      error_d     = error_q;
      if (in_nd) begin
         case (state_q)
            ST_IDLE: begin
               if (!hdr_is_header) begin
                  error_d = 1'b1;
               end else if (!hdr_dest_valid) begin
                  error_d     = 1'b1;
                  remaining_d = hdr_length;
                  if (hdr_length != '0) state_d = ST_DISCARD;
               end else begin
                  dest_d = hdr_dest;
                  if (hdr_length != '0) begin
                     remaining_d = hdr_length;
                     state_d     = ST_FORWARD;
                  end
               end
            end
            ST_FORWARD, ST_DISCARD: begin
               remaining_d = remaining_q - LEN_W'(1);
               if (remaining_q == LEN_W'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output logic: select what (if anything) is written this cycle
   always_comb begin
      fwd_en   = 1'b0;
      fwd_dest = dest_q;
      fwd_last = 1'b0;
      if (in_nd) begin
         case (state_q)
`ifdef MESSAGE_SPLITTER_STRIP_HEADER_EN
            // Headers are consumed; payload alone reaches the streams.
            ST_IDLE: ;
`else
            ST_IDLE: begin
               if (hdr_is_header && hdr_dest_valid) begin
                  fwd_en   = 1'b1;
                  fwd_dest = hdr_dest;
                  fwd_last = (hdr_length == '0);
               end
            end
`endif
            // Payload MSB is never interpreted as a header flag.
            ST_FORWARD: begin
               fwd_en   = 1'b1;
               fwd_last = (remaining_q == LEN_W'(1));
            end
            default: ;
         endcase
      end

      out_data_d = out_data_q;
      out_nd_d   = '0;
      out_last_d = '0;
      for (int k = 0; k < N_STREAMS; k++) begin
         if (fwd_en && (int'(fwd_dest) == k)) begin
            out_data_d[WIDTH*k +: WIDTH] = in_data;
            out_nd_d[k]                  = 1'b1;
            out_last_d[k]                = fwd_last;
         end
      end
   end

   assign out_data = out_data_q;
   assign out_nd   = out_nd_q;
   assign out_last = out_last_q;
   assign error    = error_q;

endmodule

// File: tb/tb_message_stream_splitter.sv
// -----------------------------------------------------------------------------
// tb_message_stream_splitter
// Table-driven bench with a scoreboard queue. Each record holds one input word
// and the outputs expected on the cycle after it is applied. A second instance
// built with N_STREAMS=3 exercises the out-of-range destination path.
// -----------------------------------------------------------------------------
module tb_message_stream_splitter;

   typedef struct packed {
      logic        sel;       // 0: 4-stream DUT, 1: 3-stream DUT
      logic [31:0] data;
      logic        nd;
      logic        hdr;       // row is a forwarded header (suppressed when stripping)
      logic        zero_all;  // expect every output at its reset value
      logic [3:0]  exp_nd;
      logic [3:0]  exp_last;
      logic        exp_err;
   } vec_t;

   logic         clk;
   logic         rst_n;
   logic [31:0]  in_data;
   logic         in_nd;
   logic [127:0] out_data;
   logic [3:0]   out_nd;
   logic [3:0]   out_last;
   logic         err;

   logic [31:0]  in3_data;
   logic         in3_nd;
   logic [95:0]  o3_data;
   logic [2:0]   o3_nd;
   logic [2:0]   o3_last;
   logic         err3;

   int tests;
   int failed;
   vec_t sb[$];
   vec_t tbl[$];

   message_stream_splitter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_nd    (in_nd),
      .out_data (out_data),
      .out_nd   (out_nd),
      .out_last (out_last),
      .error    (err)
   );

   message_stream_splitter #(.N_STREAMS(3), .LOG_N_STREAMS(2)) dut3 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in3_data),
      .in_nd    (in3_nd),
      .out_data (o3_data),
      .out_nd   (o3_nd),
      .out_last (o3_last),
      .error    (err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic sel, input logic [31:0] d, input logic nd,
                               input logic hdr, input logic [3:0] en, input logic [3:0] el,
                               input logic ee);
      vec_t v;
      v.sel = sel; v.data = d; v.nd = nd; v.hdr = hdr; v.zero_all = 1'b0;
      v.exp_nd = en; v.exp_last = el; v.exp_err = ee;
      return v;
   endfunction

   function automatic vec_t rst_row();
      vec_t v;
      v = '0;
      v.zero_all = 1'b1;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check(input vec_t e);
      logic [3:0]   a_nd;
      logic [3:0]   a_last;
      logic         a_err;
      logic [127:0] a_data;
      if (e.sel) begin
         a_nd = {1'b0, o3_nd}; a_last = {1'b0, o3_last}; a_err = err3; a_data = {32'h0, o3_data};
      end else begin
         a_nd = out_nd; a_last = out_last; a_err = err; a_data = out_data;
      end
      cmp($sformatf("out_nd[in=%h]", e.data), 128'(a_nd), 128'(e.exp_nd));
      cmp($sformatf("out_last[in=%h]", e.data), 128'(a_last), 128'(e.exp_last));
      cmp($sformatf("error[in=%h]", e.data), 128'(a_err), 128'(e.exp_err));
      if (e.zero_all) cmp("out_data_reset", a_data, 128'h0);
      for (int k = 0; k < 4; k++) begin
         if (e.exp_nd[k]) cmp($sformatf("out_data[%0d]", k), 128'(a_data[32*k +: 32]), 128'(e.data));
      end
   endtask

   // Check the previous cycle's expectation, then apply this record.
   task automatic step(input logic r, input vec_t v);
      vec_t e;
      @(negedge clk);
      if (sb.size() != 0) check(sb.pop_front());
      rst_n = r;
      if (v.sel) begin
         in3_data = v.data; in3_nd = v.nd; in_nd = 1'b0;
      end else begin
         in_data = v.data; in_nd = v.nd; in3_nd = 1'b0;
      end
      e = v;
`ifdef MESSAGE_SPLITTER_STRIP_HEADER_EN
      if (v.hdr) begin
         e.exp_nd = '0; e.exp_last = '0;
      end
`endif
      sb.push_back(e);
   endtask

   initial begin
      tests = 0; failed = 0;
      rst_n = 1'b0; in_data = '0; in_nd = 1'b0; in3_data = '0; in3_nd = 1'b0;

      // Header = 0x80000000 | len<<21 | dest<<19
      tbl.push_back(mk(0, 32'h80700000, 1, 1, 4'b0100, 4'b0000, 0)); // len 3 dest 2
      tbl.push_back(mk(0, 32'h0000000A, 1, 0, 4'b0100, 4'b0000, 0));
      tbl.push_back(mk(0, 32'h0000000B, 1, 0, 4'b0100, 4'b0000, 0));
      tbl.push_back(mk(0, 32'h0000000C, 1, 0, 4'b0100, 4'b0100, 0));
      tbl.push_back(mk(0, 32'h80080000, 1, 1, 4'b0010, 4'b0010, 0)); // back-to-back, len 0 dest 1
      tbl.push_back(mk(0, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 0));
      tbl.push_back(mk(0, 32'h80580000, 1, 1, 4'b1000, 4'b0000, 0)); // len 2 dest 3
      tbl.push_back(mk(0, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 0));
      tbl.push_back(mk(0, 32'hFFFFFFFF, 1, 0, 4'b1000, 4'b0000, 0)); // MSB-set payload
      tbl.push_back(mk(0, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 0));
      tbl.push_back(mk(0, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 0));
      tbl.push_back(mk(0, 32'h00000001, 1, 0, 4'b1000, 4'b1000, 0));
      tbl.push_back(mk(0, 32'h80200000, 1, 1, 4'b0001, 4'b0000, 0)); // len 1 dest 0
      tbl.push_back(mk(0, 32'h12345678, 1, 0, 4'b0001, 4'b0001, 0));
      tbl.push_back(mk(0, 32'h00000005, 1, 0, 4'b0000, 4'b0000, 1)); // orphan
      tbl.push_back(mk(0, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 1));
      tbl.push_back(mk(0, 32'h80700000, 1, 1, 4'b0100, 4'b0000, 1)); // routing continues after error
      tbl.push_back(mk(0, 32'h00000001, 1, 0, 4'b0100, 4'b0000, 1));
      tbl.push_back(mk(0, 32'h00000002, 1, 0, 4'b0100, 4'b0000, 1));
      tbl.push_back(mk(0, 32'h00000003, 1, 0, 4'b0100, 4'b0100, 1));
      tbl.push_back(mk(0, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 1));

      // Reset state
      step(1'b0, rst_row());
      step(1'b0, rst_row());

      for (int i = 0; i < tbl.size(); i++) step(1'b1, tbl[i]);

      // Reset after 1 of 3 payload words: partial packet abandoned, error cleared
      step(1'b1, mk(0, 32'h80600000, 1, 1, 4'b0001, 4'b0000, 1)); // len 3 dest 0
      step(1'b1, mk(0, 32'h00000011, 1, 0, 4'b0001, 4'b0000, 1));
      step(1'b0, rst_row());
      step(1'b1, mk(0, 32'h00000007, 1, 0, 4'b0000, 4'b0000, 1)); // orphan after reset
      step(1'b1, mk(0, 32'h80300000, 1, 1, 4'b0100, 4'b0000, 1)); // len 1 dest 2
      step(1'b1, mk(0, 32'h00000099, 1, 0, 4'b0100, 4'b0100, 1));
      step(1'b1, mk(0, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 1));

      // N_STREAMS=3: destination 3 rejected, payload swallowed, next packet routed
      step(1'b1, mk(1, 32'h80580000, 1, 0, 4'b0000, 4'b0000, 1)); // len 2 dest 3
      step(1'b1, mk(1, 32'h00000021, 1, 0, 4'b0000, 4'b0000, 1));
      step(1'b1, mk(1, 32'h80000022, 1, 0, 4'b0000, 4'b0000, 1)); // discarded even with MSB set
      step(1'b1, mk(1, 32'h80000000, 1, 1, 4'b0001, 4'b0001, 1)); // len 0 dest 0
      step(1'b1, mk(1, 32'h80200000, 1, 1, 4'b0001, 4'b0000, 1)); // len 1 dest 0
      step(1'b1, mk(1, 32'h000000AB, 1, 0, 4'b0001, 4'b0001, 1));
      step(1'b1, mk(1, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 1));

      @(negedge clk);
      while (sb.size() != 0) check(sb.pop_front());

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
